sum_io_rd_stream: RTL and testbench
===================================

# sum_io_rd_stream

Read-side streaming engine for the `sum_io_empty_3` byte-enable window RAM. It takes a start address and word count and issues single-word reads on RAM port 0 (`address0`/`ce0`/`q0`). It absorbs the RAM's one-cycle read latency and presents the words in address order on a valid/ready output stream. A two-entry buffer guarantees no word is lost or duplicated under arbitrary back-pressure, while sustaining one word per cycle when `m_ready` is held high.

## Interface
- `DataWidth`, 400: word width; must equal the RAM's `DataWidth`.
- `AddressWidth`, 13: address width.
- `WinBase`, 4000: first absolute address held by the RAM window.
- `WinSize`, 1000: number of words in the window.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request pulse; sampled only in IDLE.
- `start_addr`  in  AddressWidth  absolute first address.
- `len`  in  AddressWidth  number of words to read.
- `busy`  out  1  high from accepted `start` until the cycle `done` is asserted.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse coincident with `done` when the request is out of window.
- `address0`  out  AddressWidth  absolute RAM read address; the RAM subtracts its own offset.
- `ce0`  out  1  RAM read enable.
- `q0`  in  DataWidth  RAM read data, valid the cycle after `ce0`.
- `m_data`  out  DataWidth  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  marks the final word of a transfer; qualified by `m_valid`.

## Operation
- **Reset values:** all outputs are 0, FSM is IDLE, buffer is empty, in-flight flag is 0.
- **FSM states:** IDLE, CHECK, RUN.
- **IDLE:**
  - `start`=1 latches `start_addr` and `len`, sets `busy`=1, and moves to CHECK.
  - `start` is ignored in any state other than IDLE.
- **CHECK (one cycle)** evaluates the request in AddressWidth+1 bits:
  - `len`==0: pulse `done`, clear `busy`, return to IDLE. `err`=0.
  - `start_addr` < `WinBase`, or `start_addr`+`len` > `WinBase`+`WinSize`: pulse `done` and `err`, clear `busy`, return to IDLE. No `ce0` is issued.
  - Otherwise go to RUN. The first `ce0` is issued in this CHECK cycle with `address0`=`start_addr`.
- **Read issue (CHECK or RUN):**
  - `ce0`=1 when words remain to issue and either:
    - `count` + `inflight` < 2, or
    - `count` + `inflight` == 2 and a pop occurs this cycle (`m_valid` && `m_ready`).
  - `count` is the buffer occupancy (0..2). `inflight` is the previous cycle's `ce0`.
  - Each issue increments `address0` and decrements the remaining-issue counter.
- **Capture:** when `inflight`=1, `q0` is pushed into the 2-entry FIFO at the end of that cycle.
- **Output:**
  - `m_valid` = `count`!=0; `m_data` is the FIFO head.
  - `m_data`/`m_last` are stable while `m_valid` && !`m_ready`.
- **`m_last`:** set on the head entry when it is the `len`-th word of the transfer (tracked by a popped-word counter).
- **Completion:** the cycle after the handshake of the `m_last` word, `done`=1 and `busy`=0; FSM returns to IDLE.
- **Occupancy bound:** the FIFO never exceeds 2 entries; `ce0` is never issued when the push would overflow.
- **Reset mid-transfer:** the FIFO and in-flight read are flushed and the FSM returns to IDLE. A RAM word arriving after reset is discarded. No `done` is generated.

## Timing
- `start` in cycle T:
  - CHECK occurs in T+1, with first `ce0` at T+1.
  - `q0` is valid at T+2 and is pushed at the end of T+2.
  - First `m_valid`=1 at T+3.
- With `m_ready`=1 throughout: one word per cycle; word k is presented at T+3+k; `m_last` at T+2+`len`; `done` at T+3+`len`.
- No-op or error request: `done` (and `err` if applicable) at T+2. `busy` is high during T+1 only.
- A new `start` is accepted in the cycle `done` is asserted or later (FSM is IDLE).

## Test plan
- **Basic transfer:** preload word at address a = a; `start_addr`=4000, `len`=4, `m_ready`=1 → `ce0` T+1..T+4; `m_data` 4000..4003 on T+3..T+6; `m_last` only at T+6; `done` at T+7; `err`=0.
- **Back-pressure:** `len`=8 from 4100, `m_ready` pattern 1,0,0,1,0,1… → exactly 4100..4107 in order with no repeats; `m_data` is held during stalls; FIFO occupancy never exceeds 2; `m_last` only on 4107.
- **Window edges:**
  - `start_addr`=4996, `len`=4 → 4 words, last is 4999.
  - `start_addr`=4997, `len`=4 → `done`+`err` at T+2, no `ce0`.
  - `start_addr`=3999, `len`=1 → `err`.
- **Zero length:** `len`=0 → `done` at T+2; `err`=0; `ce0`, `m_valid` never asserted.
- **Reset mid-run:** `len`=10, `m_ready`=0 until FIFO full, then `reset` for 1 cycle → next cycle all outputs 0; a subsequent `start` at 4000, `len`=2 delivers exactly 4000 and 4001.
- **Start while busy:** second `start` pulse during RUN → ignored; only the first transfer's words and a single `done` appear.

Source files
------------

// File: rtl/sum_io_rd_stream.sv
// Read-side streaming engine for the sum_io_empty_3 window RAM: issues single-word
// reads on port 0 and replays them in address order on a valid/ready stream.
module sum_io_rd_stream #(
    parameter int DataWidth    = 400,
    parameter int AddressWidth = 13,
    parameter int WinBase      = 4000,
    parameter int WinSize      = 1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [AddressWidth-1:0] start_addr,
    input  logic [AddressWidth-1:0] len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [AddressWidth-1:0] address0,
    output logic                    ce0,
    input  logic [DataWidth-1:0]    q0,
    output logic [DataWidth-1:0]    m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int CW = AddressWidth + 1;

    logic [1:0]              state;
    logic [AddressWidth-1:0] len_r;
    logic [AddressWidth-1:0] issue_addr;
    logic [AddressWidth-1:0] to_issue;
    logic [AddressWidth-1:0] popped;
    logic                    inflight;

    logic [DataWidth-1:0]    fifo_mem [2];
    logic                    rd_ptr;
    logic                    wr_ptr;
    logic [1:0]              count;

    logic [CW-1:0]           req_end;
    logic                    req_zero;
    logic                    req_bad;
    logic [1:0]              occ;
    logic                    push;
    logic                    pop;
    logic                    room;
    logic                    can_issue;

    // While in CHECK, issue_addr still holds the latched start address.
    assign req_end  = {1'b0, issue_addr} + {1'b0, len_r};
    assign req_zero = (len_r == '0);
    assign req_bad  = ({1'b0, issue_addr} < CW'(WinBase)) ||
                      (req_end > CW'(WinBase + WinSize));

    assign push      = inflight;
    assign pop       = m_valid && m_ready;
    assign occ       = count + {1'b0, inflight};
    // A slot freed by this cycle's pop can be reused by a read whose data lands next cycle.
    assign room      = (occ < 2'd2) || ((occ == 2'd2) && pop);
    assign can_issue = (to_issue != '0) && room;

    always_comb begin
        ce0 = 1'b0;
        if (state == ST_CHECK)
            ce0 = !req_zero && !req_bad && can_issue;
        else if (state == ST_RUN)
            ce0 = can_issue;
    end

    assign address0 = issue_addr;
    assign busy     = (state != ST_IDLE);
    assign m_valid  = (count != 2'd0);
    assign m_data   = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last   = m_valid && (popped == len_r - 1'b1);

    // NOTE: the data storage is deliberately not reset; the pointers and occupancy
    // are, and m_data is gated by m_valid so stale contents never reach the port.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= q0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            len_r      <= '0;
            issue_addr <= '0;
            to_issue   <= '0;
            popped     <= '0;
            inflight   <= 1'b0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            inflight <= ce0;

            if (ce0) begin
                issue_addr <= issue_addr + 1'b1;
                to_issue   <= to_issue - 1'b1;
            end

            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                popped <= popped + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        issue_addr <= start_addr;
                        len_r      <= len;
                        to_issue   <= len;
                        popped     <= '0;
                        state      <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (req_zero) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (req_bad) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pop && m_last) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_io_rd_stream.sv
// Scoreboard bench for sum_io_rd_stream: directed requests push expected words and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_sum_io_rd_stream;

    localparam int DW = 400;
    localparam int AW = 13;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] address0;
    logic          ce0;
    logic [DW-1:0] q0;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    int total = 0;
    int bad   = 0;

    exp_t exp_q[$];
    bit   err_q[$];

    bit            hold_pending = 1'b0;
    logic [DW-1:0] hold_data;
    logic          hold_last;

    sum_io_rd_stream dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .start_addr(start_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .address0  (address0),
        .ce0       (ce0),
        .q0        (q0),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        logic [DW-1:0] w;
        w = '0;
        w[AW-1:0]     = a;
        w[200 +: AW]  = ~a;
        w[DW-1 -: AW] = a;
        return w;
    endfunction

    // RAM model: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (ce0)
            q0 <= word_of(address0);
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: stream handshakes, hold stability and completion pulses.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, hold_data);
                check("hold_last", m_last, hold_last);
            end
            hold_pending = m_valid && !m_ready;
            hold_data    = m_data;
            hold_last    = m_last;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h want none", m_data[AW-1:0]);
                end else begin
                    e = exp_q.pop_front();
                    check("m_data", m_data, e.data);
                    check("m_last", m_last, e.last);
                end
            end
            if (done) begin
                if (err_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want none");
                end else begin
                    check("err", err, err_q.pop_front());
                end
            end
        end
    end

    // Issues one request and runs until done; mode 0: ready=1, 1: ready pattern 1,0,0,1,0,1.
    task automatic do_xfer(input logic [AW-1:0] a, input logic [AW-1:0] n, input int mode,
                           input int restart_k, input bit exp_err,
                           output int done_k, output int ce_cnt, output int first_ce,
                           output int last_ce, output int first_valid, output int busy_k1);
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        done_k = -1; ce_cnt = 0; first_ce = -1; last_ce = -1; first_valid = -1; busy_k1 = 0;
        if (!exp_err && n != 0)
            for (int i = 0; i < int'(n); i++)
                exp_q.push_back('{word_of(a + AW'(i)), (i == int'(n) - 1)});
        err_q.push_back(exp_err);
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = a; len = n;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            start = (k == restart_k);
            if (k == restart_k) begin
                start_addr = 13'd4500;
                len        = 13'd3;
            end
            m_ready = (mode == 0) ? 1'b1 : pat[(k - 1) % 6];
            #1;
            if (k == 1) busy_k1 = int'(busy);
            if (ce0) begin
                ce_cnt++;
                if (first_ce < 0) first_ce = k;
                last_ce = k;
            end
            if (m_valid && first_valid < 0) first_valid = k;
            if (done) begin
                done_k = k;
                check("busy_low_at_done", busy, 1'b0);
                break;
            end
        end
        start = 1'b0;
        if (done_k < 0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within 200 cycles");
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        int dk, cc, fc, lc, fv, bk;
        reset = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ce0", ce0, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, '0);
        check("rst_address0", address0, '0);
        reset = 1'b0;

        // Basic transfer.
        do_xfer(13'd4000, 13'd4, 0, -1, 1'b0, dk, cc, fc, lc, fv, bk);
        check("basic_done_cycle", dk, 7);
        check("basic_ce_count", cc, 4);
        check("basic_first_ce", fc, 1);
        check("basic_last_ce", lc, 4);
        check("basic_first_valid", fv, 3);
        check("basic_busy_t1", bk, 1);

        // Back-pressure.
        do_xfer(13'd4100, 13'd8, 1, -1, 1'b0, dk, cc, fc, lc, fv, bk);
        check("bp_ce_count", cc, 8);

        // Window edges.
        do_xfer(13'd4996, 13'd4, 0, -1, 1'b0, dk, cc, fc, lc, fv, bk);
        check("edge_ok_done_cycle", dk, 7);
        do_xfer(13'd4997, 13'd4, 0, -1, 1'b1, dk, cc, fc, lc, fv, bk);
        check("edge_over_done_cycle", dk, 2);
        check("edge_over_ce_count", cc, 0);
        check("edge_over_busy_t1", bk, 1);
        do_xfer(13'd3999, 13'd1, 0, -1, 1'b1, dk, cc, fc, lc, fv, bk);
        check("edge_under_ce_count", cc, 0);

        // Zero length.
        do_xfer(13'd4000, 13'd0, 0, -1, 1'b0, dk, cc, fc, lc, fv, bk);
        check("zero_done_cycle", dk, 2);
        check("zero_ce_count", cc, 0);
        check("zero_valid_seen", fv, -1);

        // Start while busy: the second pulse during RUN must be ignored.
        do_xfer(13'd4200, 13'd5, 1, 3, 1'b0, dk, cc, fc, lc, fv, bk);
        check("restart_ce_count", cc, 5);
        repeat (6) @(posedge clk);
        #1;
        check("restart_idle_busy", busy, 1'b0);

        // Reset mid-run with a full FIFO.
        @(posedge clk);
        #1;
        m_ready = 1'b0; start = 1'b1; start_addr = 13'd4000; len = 13'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrun_valid_before_reset", m_valid, 1'b1);
        check("midrun_ce_blocked", ce0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrun_busy", busy, 1'b0);
        check("midrun_m_valid", m_valid, 1'b0);
        check("midrun_m_data", m_data, '0);
        check("midrun_m_last", m_last, 1'b0);
        check("midrun_ce0", ce0, 1'b0);
        check("midrun_address0", address0, '0);
        check("midrun_done", done, 1'b0);
        repeat (3) @(posedge clk);
        do_xfer(13'd4000, 13'd2, 0, -1, 1'b0, dk, cc, fc, lc, fv, bk);
        check("post_reset_done_cycle", dk, 5);

        repeat (4) @(posedge clk);
        check("no_pending_done", err_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
